// File: rtl/startup_sequencer.sv
// One-shot power-on sequencer: after a start pulse, issues NUM_STEPS indexed commands
// over valid/ready with a DELAY gap between them. Times out to a retryable ERROR state.
module startup_sequencer #(
   parameter int          NUM_STEPS = 4,
   parameter logic [31:0] DELAY     = 32'd1000,
   parameter logic [31:0] TIMEOUT   = 32'd100000,
   parameter int          IDXW      = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   output logic            cmd_valid,
   input  logic            cmd_ready,
   output logic [IDXW-1:0] cmd_index,
   output logic            busy,
   output logic            done,
   output logic            error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_STEPS - 1);
   localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);

   state_t          state;
   state_t          state_nxt;
   logic [31:0]     tcnt;
   logic [31:0]     tcnt_nxt;
   logic [31:0]     wcnt;
   logic [31:0]     wcnt_nxt;
   logic [IDXW-1:0] index_nxt;
   logic            valid_nxt;
   logic            busy_nxt;
   logic            done_nxt;
   logic            error_nxt;
   logic            accept;

   // cmd_valid is high exactly in ISSUE, so the handshake reduces to this
   assign accept = (state == S_ISSUE) && cmd_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         tcnt      <= '0;
         wcnt      <= '0;
         cmd_index <= '0;
         cmd_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_nxt;
         tcnt      <= tcnt_nxt;
         wcnt      <= wcnt_nxt;
         cmd_index <= index_nxt;
         cmd_valid <= valid_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         error     <= error_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (accept)
               state_nxt = (cmd_index == LAST_IDX) ? S_DONE : S_WAIT;
            else if (tcnt == TIMEOUT)
               state_nxt = S_ERROR;
         end
         S_WAIT:  if (wcnt == DELAY) state_nxt = S_ISSUE;
         S_DONE:  state_nxt = S_DONE;
         S_ERROR: if (start) state_nxt = S_ISSUE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it
   always_comb begin
      index_nxt = cmd_index;
      if (accept && (cmd_index != LAST_IDX))
         index_nxt = cmd_index + ONE_IDX;
      else if (((state == S_IDLE) || (state == S_ERROR)) && start)
         index_nxt = '0;

      tcnt_nxt = '0;
      if (state_nxt == S_ISSUE)
         tcnt_nxt = (state == S_ISSUE) ? tcnt + 32'd1 : 32'd1;

      wcnt_nxt = '0;
      if (state_nxt == S_WAIT)
         wcnt_nxt = (state == S_WAIT) ? wcnt + 32'd1 : 32'd1;

      valid_nxt = (state_nxt == S_ISSUE);
      busy_nxt  = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
      done_nxt  = (state_nxt == S_DONE);
      error_nxt = (state_nxt == S_ERROR);
   end

endmodule

// File: tb/tb_startup_sequencer.sv
// Directed bench for startup_sequencer (NUM_STEPS=3, DELAY=4, TIMEOUT=8, plus a NUM_STEPS=1 instance).
module tb_startup_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [1:0] cmd_index;
   logic       busy;
   logic       done;
   logic       error;

   logic       s_start;
   logic       s_ready;
   logic       s_valid;
   logic [0:0] s_index;
   logic       s_busy;
   logic       s_done;
   logic       s_error;

   logic [5:0] obs;
   logic [4:0] s_obs;

   int checks   = 0;
   int failures = 0;

   assign obs   = {cmd_valid, cmd_index, busy, done, error};
   assign s_obs = {s_valid, s_index, s_busy, s_done, s_error};

   always #5 clock = ~clock;

   startup_sequencer #(.NUM_STEPS(3), .DELAY(32'd4), .TIMEOUT(32'd8)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_index (cmd_index),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   startup_sequencer #(.NUM_STEPS(1), .DELAY(32'd4), .TIMEOUT(32'd8)) u_single (
      .clock     (clock),
      .reset     (reset),
      .start     (s_start),
      .cmd_valid (s_valid),
      .cmd_ready (s_ready),
      .cmd_index (s_index),
      .busy      (s_busy),
      .done      (s_done),
      .error     (s_error)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; cmd_ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   // {valid, index, busy, done, error} for cycle c after the start edge, cmd_ready tied high
   function automatic logic [5:0] exp_tied(input int c);
      logic       v;
      logic [1:0] i;
      v = (c == 1) || (c == 6) || (c == 11);
      i = (c == 1) ? 2'd0 : (c <= 6) ? 2'd1 : 2'd2;
      return {v, i, (c < 12), (c >= 12), 1'b0};
   endfunction

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; cmd_ready = 1'b1; s_start = 1'b1; s_ready = 1'b1;
      tick(); tick();
      checks++;
      if (obs !== 6'b0) begin
         failures++; $display("FAIL reset_hold obs=%b exp=%b", obs, 6'b0);
      end
      checks++;
      if (s_obs !== 5'b0) begin
         failures++; $display("FAIL reset_hold_single obs=%b exp=%b", s_obs, 5'b0);
      end
      start = 1'b0; s_start = 1'b0; cmd_ready = 1'b0; s_ready = 1'b0;
      reset = 1'b0;
      tick(); tick();
      checks++;
      if (obs !== 6'b0) begin
         failures++; $display("FAIL reset_idle obs=%b exp=%b", obs, 6'b0);
      end
   endtask

   task automatic run_tied(input bit extra_starts, input string name);
      do_reset();
      cmd_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         checks++;
         if (obs !== exp_tied(c)) begin
            failures++;
            $display("FAIL %s_c%0d obs=%b exp=%b", name, c, obs, exp_tied(c));
         end
         start = extra_starts && ((c == 3) || (c == 6) || (c == 13));
         tick();
         start = 1'b0;
      end
   endtask

   task automatic test_ready_tied();
      run_tied(1'b0, "tied");
   endtask

   task automatic test_extra_start();
      run_tied(1'b1, "xstart");
   endtask

   task automatic test_stall();
      int n;
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (cmd_valid !== 1'b1 && n < 20) begin tick(); n++; end
         checks++;
         if (cmd_valid !== 1'b1) begin
            failures++; $display("FAIL stall_wait%0d valid=%b exp=1", k, cmd_valid);
         end
         for (int j = 0; j < 4; j++) begin
            checks++;
            if ({cmd_valid, cmd_index, error} !== {1'b1, 2'(k), 1'b0}) begin
               failures++;
               $display("FAIL stall_hold%0d_%0d got=%b exp=%b", k, j,
                        {cmd_valid, cmd_index, error}, {1'b1, 2'(k), 1'b0});
            end
            if (j < 3) tick();
         end
         cmd_ready = 1'b1;
         tick();
         cmd_ready = 1'b0;
         checks++;
         if (k < 2) begin
            if (obs !== {1'b0, 2'(k + 1), 1'b1, 1'b0, 1'b0}) begin
               failures++;
               $display("FAIL stall_acc%0d obs=%b exp=%b", k, obs, {1'b0, 2'(k + 1), 3'b100});
            end
         end else if (obs !== 6'b010010) begin
            failures++; $display("FAIL stall_done obs=%b exp=%b", obs, 6'b010010);
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (obs !== 6'b100100) begin
            failures++; $display("FAIL tmo_valid_c%0d obs=%b exp=%b", c, obs, 6'b100100);
         end
         tick();
      end
      checks++;
      if (obs !== 6'b000001) begin
         failures++; $display("FAIL tmo_error obs=%b exp=%b", obs, 6'b000001);
      end
      cmd_ready = 1'b1;
      tick(); tick(); tick();
      cmd_ready = 1'b0;
      checks++;
      if (obs !== 6'b000001) begin
         failures++; $display("FAIL tmo_sticky obs=%b exp=%b", obs, 6'b000001);
      end
   endtask

   task automatic test_late_accept();
      int n;
      do_reset();
      cmd_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      cmd_ready = 1'b0;
      n = 0;
      while (cmd_valid !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (cmd_index !== 2'd1 || cmd_valid !== 1'b1) begin
         failures++; $display("FAIL late_idx1 valid=%b idx=%0d exp valid=1 idx=1", cmd_valid, cmd_index);
      end
      for (int j = 0; j < 7; j++) tick();
      checks++;
      if (obs !== 6'b101100) begin
         failures++; $display("FAIL late_8th obs=%b exp=%b", obs, 6'b101100);
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      checks++;
      if (obs !== 6'b010100) begin
         failures++; $display("FAIL late_accept obs=%b exp=%b", obs, 6'b010100);
      end
      n = 0;
      while (cmd_valid !== 1'b1 && n < 20) begin tick(); n++; end
      for (int j = 0; j < 8; j++) tick();
      checks++;
      if (obs !== 6'b010001) begin
         failures++; $display("FAIL late_err2 obs=%b exp=%b", obs, 6'b010001);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (obs !== 6'b100100) begin
         failures++; $display("FAIL late_retry obs=%b exp=%b", obs, 6'b100100);
      end
      cmd_ready = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 40) begin tick(); n++; end
      checks++;
      if (obs !== 6'b010010) begin
         failures++; $display("FAIL late_done obs=%b exp=%b", obs, 6'b010010);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cmd_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      checks++;
      if (obs !== exp_tied(3)) begin
         failures++; $display("FAIL mid_wait obs=%b exp=%b", obs, exp_tied(3));
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (obs !== 6'b0) begin
         failures++; $display("FAIL mid_reset obs=%b exp=%b", obs, 6'b0);
      end
      tick(); tick();
      checks++;
      if (obs !== 6'b0) begin
         failures++; $display("FAIL mid_idle obs=%b exp=%b", obs, 6'b0);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         checks++;
         if (obs !== exp_tied(c)) begin
            failures++; $display("FAIL mid_replay_c%0d obs=%b exp=%b", c, obs, exp_tied(c));
         end
         tick();
      end
   endtask

   task automatic test_single();
      do_reset();
      s_ready = 1'b1;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      checks++;
      if (s_obs !== 5'b10100) begin
         failures++; $display("FAIL single_issue obs=%b exp=%b", s_obs, 5'b10100);
      end
      tick();
      checks++;
      if (s_obs !== 5'b00010) begin
         failures++; $display("FAIL single_done obs=%b exp=%b", s_obs, 5'b00010);
      end
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      tick();
      checks++;
      if (s_obs !== 5'b00010) begin
         failures++; $display("FAIL single_sticky obs=%b exp=%b", s_obs, 5'b00010);
      end
   endtask

   initial begin
      test_reset();
      test_ready_tied();
      test_stall();
      test_timeout();
      test_late_accept();
      test_extra_start();
      test_reset_mid();
      test_single();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
